seg7_scan_controller: RTL and testbench



---
 rtl/seg7_pkg.sv | 11 +
 rtl/seg7_hex_decoder.sv | 31 +++
 rtl/seg7_scan_controller.sv | 116 +++++++++++
 tb/tb_seg7_scan_controller.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and state type for the seven-segment scan controller
package seg7_pkg;

   localparam int         NUM_DIGITS = 3;
   localparam int         VALUE_W    = 10;
   localparam logic [6:0] SEG_BLANK  = 7'h7F;
   localparam logic [2:0] AN_OFF     = 3'b111;

   typedef enum logic {S_SHOW, S_PENDING} scan_state_t;

endpackage

// File: rtl/seg7_hex_decoder.sv
// rtl/seg7_hex_decoder.sv - 4-bit nibble to active-low seven-segment pattern (gfedcba)
module seg7_hex_decoder (
   input  logic [3:0] nib_i,
   output logic [6:0] seg_o
);

   // full 0-F table, a segment is lit when its bit is 0
   always_comb begin
      seg_o = 7'h7F;
      case (nib_i)
         4'h0: seg_o = 7'b1000000;
         4'h1: seg_o = 7'b1111001;
         4'h2: seg_o = 7'b0100100;
         4'h3: seg_o = 7'b0110000;
         4'h4: seg_o = 7'b0011001;
         4'h5: seg_o = 7'b0010010;
         4'h6: seg_o = 7'b0000010;
         4'h7: seg_o = 7'b1111000;
         4'h8: seg_o = 7'b0000000;
         4'h9: seg_o = 7'b0010000;
         4'hA: seg_o = 7'b0001000;
         4'hB: seg_o = 7'b0000011;
         4'hC: seg_o = 7'b1000110;
         4'hD: seg_o = 7'b0100001;
         4'hE: seg_o = 7'b0000110;
         4'hF: seg_o = 7'b0001110;
         default: seg_o = 7'h7F;
      endcase
   end

endmodule

// File: rtl/seg7_scan_controller.sv
// rtl/seg7_scan_controller.sv - 3-digit multiplexed hex display scanner with frame-aligned value commit
module seg7_scan_controller
   import seg7_pkg::*;
#(
   parameter int SCAN_DIV = 50000,
   parameter int GUARD    = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [VALUE_W-1:0]    value,
   input  logic                  blank_lz,
   output logic                  ready,
   output logic [NUM_DIGITS-1:0] an,
   output logic [6:0]            seg
);

   localparam int             CNT_W    = $clog2(SCAN_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] GUARD_C  = CNT_W'(GUARD);

   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [1:0]            idx_q, idx_d;
   scan_state_t           state_q, state_d;
   logic [VALUE_W-1:0]    disp_q, disp_d;
   logic [VALUE_W-1:0]    pend_q, pend_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic [6:0]            seg_q, seg_d;

   logic       tick;
   logic       frame_end;
   logic [3:0] nib;
   logic [6:0] dec_seg;
   logic       blank2;
   logic       blank1;
   logic       digit_blank;

   assign tick      = (cnt_q == CNT_LAST);
   assign frame_end = tick && (idx_q == 2'd2);
   assign ready     = (state_q == S_SHOW);
   assign an        = an_q;
   assign seg       = seg_q;

   // prescaler, digit index and the load/commit handshake; disp only changes at frame end
   always_comb begin
      cnt_d   = tick ? '0 : cnt_q + 1'b1;
      idx_d   = idx_q;
      state_d = state_q;
      pend_d  = pend_q;
      disp_d  = disp_q;
      if (tick) begin
         idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
      end
      case (state_q)
         S_SHOW: begin
            if (load) begin
               pend_d  = value;
               state_d = S_PENDING;
            end
         end
         S_PENDING: begin
            if (frame_end) begin
               disp_d  = pend_q;
               state_d = S_SHOW;
            end
         end
         default: state_d = S_SHOW;
      endcase
   end

   // pick the nibble of the digit currently being scanned
   always_comb begin
      nib = disp_q[3:0];
      case (idx_q)
         2'd0:    nib = disp_q[3:0];
         2'd1:    nib = disp_q[7:4];
         default: nib = {2'b00, disp_q[9:8]};
      endcase
   end

   seg7_hex_decoder u_dec (
      .nib_i (nib),
      .seg_o (dec_seg)
   );

   // leading-zero suppression cascades down from the top digit; digit0 always shows
   always_comb begin
      blank2      = blank_lz && (disp_q[9:8] == 2'b00);
      blank1      = blank2 && (disp_q[7:4] == 4'h0);
      digit_blank = ((idx_q == 2'd2) && blank2) || ((idx_q == 2'd1) && blank1);
      seg_d       = digit_blank ? SEG_BLANK : dec_seg;
      an_d        = (cnt_q < GUARD_C) ? AN_OFF : ~(3'b001 << idx_q);
   end

   // all state and the display pins update together; reset returns to a blank, empty display
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         idx_q   <= 2'd0;
         state_q <= S_SHOW;
         disp_q  <= '0;
         pend_q  <= '0;
         an_q    <= AN_OFF;
         seg_q   <= SEG_BLANK;
      end else begin
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         state_q <= state_d;
         disp_q  <= disp_d;
         pend_q  <= pend_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
      end
   end

endmodule

// File: tb/tb_seg7_scan_controller.sv
// tb/tb_seg7_scan_controller.sv - directed self-checking bench for seg7_scan_controller
module tb_seg7_scan_controller;

   localparam int SCAN_DIV = 4;
   localparam int GUARD    = 1;

   localparam logic [6:0] P0  = 7'b1000000;
   localparam logic [6:0] P1  = 7'b1111001;
   localparam logic [6:0] P2  = 7'b0100100;
   localparam logic [6:0] P3  = 7'b0110000;
   localparam logic [6:0] P5  = 7'b0010010;
   localparam logic [6:0] P6  = 7'b0000010;
   localparam logic [6:0] P7  = 7'b1111000;
   localparam logic [6:0] PA  = 7'b0001000;
   localparam logic [6:0] PB  = 7'b0000011;
   localparam logic [6:0] PC  = 7'b1000110;
   localparam logic [6:0] PD  = 7'b0100001;
   localparam logic [6:0] BLK = 7'h7F;

   logic       clk = 1'b0;
   logic       reset;
   logic       load;
   logic [9:0] value;
   logic       blank_lz;
   logic       ready;
   logic [2:0] an;
   logic [6:0] seg;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [9:0] value;
      logic       blank;
      logic       pulse;
      logic [6:0] s0;
      logic [6:0] s1;
      logic [6:0] s2;
   } vec_t;

   vec_t vecs [7];

   always #5 clk = ~clk;

   seg7_scan_controller #(
      .SCAN_DIV (SCAN_DIV),
      .GUARD    (GUARD)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .value    (value),
      .blank_lz (blank_lz),
      .ready    (ready),
      .an       (an),
      .seg      (seg)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // whatever digit is lit must still show the previously committed pattern
   task automatic check_old(input logic [2:0][6:0] old);
      case (an)
         3'b110:  check("hold_d0", 32'(seg), 32'(old[0]));
         3'b101:  check("hold_d1", 32'(seg), 32'(old[1]));
         3'b011:  check("hold_d2", 32'(seg), 32'(old[2]));
         3'b111:  ;
         default: check("an_onehot", 32'(an), 32'(3'b111));
      endcase
   endtask

   // called at the negedge right after a frame-end edge; checks one whole frame
   task automatic capture_frame(input string tag, input logic [2:0][6:0] exp);
      logic [2:0] e_an;
      for (int k = 1; k <= 12; k++) begin
         int cnt;
         int idx;
         @(negedge clk);
         cnt  = (k - 1) % SCAN_DIV;
         idx  = (k - 1) / SCAN_DIV;
         e_an = 3'b001 << idx;
         e_an = (cnt < GUARD) ? 3'b111 : ~e_an;
         check({tag, "_an"}, 32'(an), 32'(e_an));
         check({tag, "_seg"}, 32'(seg), 32'(exp[idx]));
      end
   endtask

   task automatic load_and_commit(input string tag, input vec_t v, input logic [2:0][6:0] old);
      value = v.value;
      load  = 1'b1;
      @(negedge clk);
      load  = 1'b0;
      check({tag, "_ready_drop"}, 32'(ready), 32'(1'b0));
      if (v.pulse) begin
         check_old(old);
         value = 10'h3FF;
         load  = 1'b1;
         @(negedge clk);
         load  = 1'b0;
      end
      for (int i = 0; i < 3 * SCAN_DIV + 4 && ready !== 1'b1; i++) begin
         check_old(old);
         @(negedge clk);
      end
      check({tag, "_ready_rise"}, 32'(ready), 32'(1'b1));
      blank_lz = v.blank;
      capture_frame(tag, {v.s2, v.s1, v.s0});
   endtask

   initial begin
      logic [2:0][6:0] old;
      logic [2:0]      e_an;
      vec_t            v;

      vecs[0] = '{10'h2A5, 1'b0, 1'b1, P5,  PA,  P2};
      vecs[1] = '{10'h007, 1'b1, 1'b0, P7,  BLK, BLK};
      vecs[2] = '{10'h007, 1'b0, 1'b0, P7,  P0,  P0};
      vecs[3] = '{10'h0B3, 1'b1, 1'b0, P3,  PB,  BLK};
      vecs[4] = '{10'h10C, 1'b1, 1'b0, PC,  P0,  P1};
      vecs[5] = '{10'h000, 1'b1, 1'b0, P0,  BLK, BLK};
      vecs[6] = '{10'h3D6, 1'b0, 1'b0, P6,  PD,  P3};

      reset    = 1'b1;
      load     = 1'b0;
      value    = 10'h000;
      blank_lz = 1'b0;

      // reset held three cycles
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_ready", 32'(ready), 32'(1'b1));
         check("rst_an", 32'(an), 32'(3'b111));
         check("rst_seg", 32'(seg), 32'(BLK));
      end
      reset = 1'b0;

      // scan order after release with an empty display
      for (int e = 1; e <= 14; e++) begin
         int cnt;
         int idx;
         @(negedge clk);
         cnt  = (e - 1) % SCAN_DIV;
         idx  = ((e - 1) / SCAN_DIV) % 3;
         e_an = 3'b001 << idx;
         e_an = (cnt < GUARD) ? 3'b111 : ~e_an;
         check("scan_an", 32'(an), 32'(e_an));
         check("scan_seg", 32'(seg), 32'(P0));
      end

      // table of loads, each committed and observed for one full frame
      old = {P0, P0, P0};
      for (int i = 0; i < 7; i++) begin
         v = vecs[i];
         load_and_commit($sformatf("vec%0d", i), v, old);
         old = {v.s2, v.s1, v.s0};
      end

      // load sampled on the frame-end edge waits for the following frame end
      for (int i = 0; i < 11; i++) begin
         check_old(old);
         @(negedge clk);
      end
      value = 10'h155;
      load  = 1'b1;
      @(negedge clk);
      load  = 1'b0;
      check("fe_ready_drop", 32'(ready), 32'(1'b0));
      for (int i = 1; i <= 11; i++) begin
         check_old(old);
         @(negedge clk);
         check("fe_ready_low", 32'(ready), 32'(1'b0));
      end
      check_old(old);
      @(negedge clk);
      check("fe_ready_rise", 32'(ready), 32'(1'b1));
      blank_lz = 1'b0;
      capture_frame("fe", {P1, P5, P5});

      // reset while pending discards the pending value
      value = 10'h3FF;
      load  = 1'b1;
      @(negedge clk);
      load  = 1'b0;
      check("rp_ready_drop", 32'(ready), 32'(1'b0));
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rp_ready", 32'(ready), 32'(1'b1));
      check("rp_an", 32'(an), 32'(3'b111));
      check("rp_seg", 32'(seg), 32'(BLK));
      @(negedge clk);
      reset = 1'b0;
      capture_frame("rp", {P0, P0, P0});
      check("rp_ready_after", 32'(ready), 32'(1'b1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
